crypto_trading_core: RTL and testbench

Single-clock, fixed-latency cross-pair arbitrage detector on the market-data path.
- Samples a BTC and an ETH price every cycle and scales ETH by a fixed BTC/ETH ratio.
- Asserts a trade trigger when the BTC–scaled-ETH spread exceeds a threshold.
- Reports the BTC price the decision was made on.
- Sits between the feed decoder and order-generation logic.

---
 rtl/crypto_trading_pkg.sv | 24 ++
 rtl/crypto_trading_core_price_scaler.sv | 27 ++
 rtl/crypto_trading_core.sv | 121 ++++++++++++
 tb/tb_crypto_trading_core.sv | 139 +++++++++++++
 4 files changed

// File: rtl/crypto_trading_pkg.sv
// Shared types and helpers for the crypto_trading_core arbitrage detector.
// Prices are unsigned Q16.48; the BTC/ETH ratio is unsigned Q8.8.
package crypto_trading_pkg;

    localparam int unsigned INT_BITS        = 16;
    localparam int unsigned FRAC_BITS       = 48;
    localparam int unsigned RATIO_FRAC_BITS = 8;
    localparam int unsigned PRICE_W         = INT_BITS + FRAC_BITS;
    localparam int unsigned PROD_W          = PRICE_W + 16;

    typedef logic [PRICE_W-1:0] price_t;

    // Q16.48 x Q8.8 rescaled back to Q16.48; anything past 16 integer bits saturates.
    function automatic price_t sat_scale(input price_t p, input logic [15:0] ratio);
        logic [PROD_W-1:0] prod;
        prod = {16'd0, p} * {64'd0, ratio};
        if (prod[PROD_W-1:PRICE_W+RATIO_FRAC_BITS] != 8'd0) begin
            sat_scale = {PRICE_W{1'b1}};
        end else begin
            sat_scale = prod[RATIO_FRAC_BITS +: PRICE_W];
        end
    endfunction

endpackage

// File: rtl/crypto_trading_core_price_scaler.sv
// Pipeline stage 2 of crypto_trading_core: scale the ETH price by the BTC/ETH
// ratio with saturation and register the result.
module price_scaler
    import crypto_trading_pkg::*;
#(
    parameter logic [15:0] RATIO_Q8_8 = 16'h1100
) (
    input  logic   clk,
    input  logic   rst,
    input  price_t eth_price,
    output price_t eth_scaled
);

    price_t eth_scaled_r;

    // Scaled-price register, cleared by reset so stale samples never survive it.
    always_ff @(posedge clk) begin
        if (rst) begin
            eth_scaled_r <= 64'd0;
        end else begin
            eth_scaled_r <= sat_scale(eth_price, RATIO_Q8_8);
        end
    end

    assign eth_scaled = eth_scaled_r;

endmodule

// File: rtl/crypto_trading_core.sv
// Fixed-latency (3 edges) BTC vs. scaled-ETH arbitrage trigger.
// Optional macro TRADE_COOLDOWN_EN turns the trigger into pulses separated by a cooldown.
module crypto_trading_core
    import crypto_trading_pkg::*;
#(
    parameter logic [15:0]  RATIO_Q8_8   = 16'h1100,
    parameter price_t       TRIG_THRESH  = 64'h0100_0000_0000_0000,
    parameter int unsigned  COOLDOWN_CYC = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  price_t btc_price,
    input  price_t eth_price,
    output logic   trade_trigger,
    output price_t trade_price
);

    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYC);

    price_t btc_s1_r;
    price_t eth_s1_r;
    price_t btc_s2_r;
    logic   eth_nz_s2_r;
    price_t eth_scaled_s;
    price_t spread_s;
    logic   cond_s;
    logic   fire_s;
    logic   trade_trigger_r;
    price_t trade_price_r;

    // Input sample stage plus the BTC/validity side-band that travels alongside the scaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            btc_s1_r    <= 64'd0;
            eth_s1_r    <= 64'd0;
            btc_s2_r    <= 64'd0;
            eth_nz_s2_r <= 1'b0;
        end else begin
            btc_s1_r    <= btc_price;
            eth_s1_r    <= eth_price;
            btc_s2_r    <= btc_s1_r;
            eth_nz_s2_r <= (eth_s1_r != 64'd0);
        end
    end

    price_scaler #(
        .RATIO_Q8_8 (RATIO_Q8_8)
    ) u_price_scaler (
        .clk        (clk),
        .rst        (rst),
        .eth_price  (eth_s1_r),
        .eth_scaled (eth_scaled_s)
    );

    // Absolute spread (larger minus smaller) and the raw trade condition.
    always_comb begin
        spread_s = 64'd0;
        if (btc_s2_r >= eth_scaled_s) begin
            spread_s = btc_s2_r - eth_scaled_s;
        end else begin
            spread_s = eth_scaled_s - btc_s2_r;
        end
        cond_s = (spread_s > TRIG_THRESH) && (btc_s2_r != 64'd0) && eth_nz_s2_r;
    end

`ifdef TRADE_COOLDOWN_EN
    logic [7:0] cooldown_r;
    logic [7:0] cooldown_nxt_s;

    // A trigger is only allowed once the cooldown has drained; firing reloads it.
    always_comb begin
        fire_s         = 1'b0;
        cooldown_nxt_s = cooldown_r;
        if (cooldown_r != 8'd0) begin
            cooldown_nxt_s = cooldown_r - 8'd1;
        end else if (cond_s) begin
            fire_s         = 1'b1;
            cooldown_nxt_s = COOLDOWN_LOAD;
        end else begin
            cooldown_nxt_s = 8'd0;
        end
    end

    // Cooldown counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown_r <= 8'd0;
        end else begin
            cooldown_r <= cooldown_nxt_s;
        end
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^COOLDOWN_LOAD;

    // Without cooldown the trigger simply follows the condition.
    always_comb begin
        fire_s = cond_s;
    end
`endif

    // Output registers; the price only moves when a trigger is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            trade_trigger_r <= 1'b0;
            trade_price_r   <= 64'd0;
        end else begin
            trade_trigger_r <= fire_s;
            if (fire_s) begin
                trade_price_r <= btc_s2_r;
            end else begin
                trade_price_r <= trade_price_r;
            end
        end
    end

    assign trade_trigger = trade_trigger_r;
    assign trade_price   = trade_price_r;

endmodule

// File: tb/tb_crypto_trading_core.sv
// Directed self-checking bench for crypto_trading_core with hand-computed expectations.
// Honours TRADE_COOLDOWN_EN for the continuous-trigger section.
module tb_crypto_trading_core;

    localparam logic [63:0] BTC_43200 = 64'hA8C0_0000_0000_0000;
    localparam logic [63:0] BTC_43520 = 64'hAA00_0000_0000_0000;
    localparam logic [63:0] BTC_43264 = 64'hA900_0000_0000_0000;
    localparam logic [63:0] BTC_256   = 64'h0100_0000_0000_0000;
    localparam logic [63:0] ETH_2560  = 64'h0A00_0000_0000_0000;
    localparam logic [63:0] ETH_BIG   = 64'hFFFF_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic [63:0] btc_price;
    logic [63:0] eth_price;
    logic        trade_trigger;
    logic [63:0] trade_price;

    int evaluated = 0;
    int failures  = 0;

    crypto_trading_core dut (
        .clk           (clk),
        .rst           (rst),
        .btc_price     (btc_price),
        .eth_price     (eth_price),
        .trade_trigger (trade_trigger),
        .trade_price   (trade_price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btc_price = 64'd0;
        eth_price = 64'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hold one price pair for three edges, then compare trigger and price.
    task automatic run_pair(input string tag, input logic [63:0] btc, input logic [63:0] eth,
                            input logic exp_trig, input logic [63:0] exp_price);
        do_reset();
        btc_price = btc;
        eth_price = eth;
        tick();
        tick();
        tick();
        check({tag, "_trig"}, {63'd0, trade_trigger}, {63'd0, exp_trig});
        check({tag, "_price"}, trade_price, exp_price);
    endtask

    initial begin
        logic exp_t;

        rst       = 1'b1;
        btc_price = 64'd0;
        eth_price = 64'd0;
        tick();
        tick();
        check("rst_trig", {63'd0, trade_trigger}, 64'd0);
        check("rst_price", trade_price, 64'd0);
        rst = 1'b0;
        btc_price = BTC_43200;
        eth_price = ETH_2560;
        tick();
        check("post_rst_e1", {63'd0, trade_trigger}, 64'd0);
        tick();
        check("post_rst_e2", {63'd0, trade_trigger}, 64'd0);
        tick();
        check("first_trig", {63'd0, trade_trigger}, 64'd1);
        check("first_price", trade_price, BTC_43200);

        run_pair("basic",      BTC_43200, ETH_2560, 1'b1, BTC_43200);
        run_pair("spread0",    BTC_43520, ETH_2560, 1'b0, 64'd0);
        run_pair("spread_eq",  BTC_43264, ETH_2560, 1'b0, 64'd0);
        run_pair("eth_zero",   BTC_43200, 64'd0,    1'b0, 64'd0);
        run_pair("btc_zero",   64'd0,     ETH_2560, 1'b0, 64'd0);
        run_pair("saturate",   BTC_43200, ETH_BIG,  1'b1, BTC_43200);
        run_pair("neg_dir",    BTC_256,   ETH_2560, 1'b1, BTC_256);

        // Triggering sample killed by reset while it sits in stage 2.
        do_reset();
        btc_price = BTC_43200;
        eth_price = ETH_2560;
        tick();
        btc_price = 64'd0;
        eth_price = 64'd0;
        tick();
        rst = 1'b1;
        tick();
        check("flush_trig_rst", {63'd0, trade_trigger}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_trig", {63'd0, trade_trigger}, 64'd0);
        end
        check("flush_price", trade_price, 64'd0);

        // Constant triggering condition.
        do_reset();
        btc_price = BTC_43200;
        eth_price = ETH_2560;
        tick();
        tick();
        tick();
        check("cont_first", {63'd0, trade_trigger}, 64'd1);
        for (int i = 1; i <= 19; i++) begin
            tick();
`ifdef TRADE_COOLDOWN_EN
            exp_t = ((i % 9) == 0);
`else
            exp_t = 1'b1;
`endif
            check("cont_trig", {63'd0, trade_trigger}, {63'd0, exp_t});
        end
        check("cont_price", trade_price, BTC_43200);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
